// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC source codes,
// the bubble instruction word and the fetch FSM state encoding.
package pipe_pkg;

    // Next-PC source codes driven by the decode control unit.
    localparam logic [1:0] PCS_SEQ = 2'b00;  // pc + 4
    localparam logic [1:0] PCS_BR  = 2'b01;  // conditional branch target
    localparam logic [1:0] PCS_JR  = 2'b10;  // register-indirect jump
    localparam logic [1:0] PCS_J   = 2'b11;  // absolute jump / jal

    // sll $0,$0,0 -- the architectural no-op injected as a pipeline bubble.
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        FS_IDLE  = 2'b00,  // no request outstanding (after reset)
        FS_FETCH = 2'b01,  // request outstanding at imem_addr = pc
        FS_HOLD  = 2'b10   // word fetched, parked in hold_buf until decode accepts
    } fetch_state_e;

    // Sequential successor of a PC; wraps modulo 2^32.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc_val);
        return pc_val + 32'd4;
    endfunction

endpackage

// File: rtl/pipe_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the instruction memory (slave).
interface pipe_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pipe_npc_sel.sv
// Next-PC selection: pc+4 adder, decode-target mux and pending-redirect
// fallback. Purely combinational.
module pipe_npc_sel
    import pipe_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        redirect_pending,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc4,
    output logic [31:0] target,
    output logic [31:0] npc
);

    // Choose the decode-requested target, then apply live/pending/sequential priority.
    always_comb begin
        pc4    = pc_inc(pc);
        target = pc4;
        npc    = pc4;
        case (pcsource)
            PCS_BR:  target = bpc;
            PCS_JR:  target = rpc;
            PCS_J:   target = jpc;
            default: target = pc4;
        endcase
        // A live request from decode always wins; decode holds a bubble while a
        // captured redirect is pending, so the two never compete in practice.
        if (pcsource != PCS_SEQ) begin
            npc = target;
        end else if (redirect_pending) begin
            npc = redirect_pc;
        end else begin
            npc = pc4;
        end
    end

endmodule

// File: rtl/pipe_fetch_unit.sv
// Instruction-fetch stage and IF/ID pipeline register. Owns the PC, drives
// the instruction-memory handshake and delivers dpc4/dinst to decode while
// honouring decode stalls, memory wait states and the branch delay slot.
module pipe_fetch_unit
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = pipe_pkg::NOP_INST
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               nostall,
    input  logic [1:0]         pcsource,
    input  logic [31:0]        bpc,
    input  logic [31:0]        rpc,
    input  logic [31:0]        jpc,
    pipe_fetch_unit_if.master  imem,
    output logic [31:0]        pc,
    output logic [31:0]        dpc4,
    output logic [31:0]        dinst
);

    fetch_state_e state_r;
    logic         req_r;
    logic [31:0]  pc_r;
    logic [31:0]  dpc4_r;
    logic [31:0]  dinst_r;
    logic [31:0]  hold_buf_r;
    logic         redirect_pending_r;
    logic [31:0]  redirect_pc_r;

    logic         word_avail_s;
    logic [31:0]  word_s;
    logic         fire_s;
    logic         branch_s;
    logic [31:0]  pc4_s;
    logic [31:0]  target_s;
    logic [31:0]  npc_s;

    pipe_npc_sel u_npc_sel (
        .pc               (pc_r),
        .pcsource         (pcsource),
        .bpc              (bpc),
        .rpc              (rpc),
        .jpc              (jpc),
        .redirect_pending (redirect_pending_r),
        .redirect_pc      (redirect_pc_r),
        .pc4              (pc4_s),
        .target           (target_s),
        .npc              (npc_s)
    );

    // Word availability and the IF/ID advance condition; ack is only meaningful in FETCH.
    always_comb begin
        word_avail_s = ((state_r == FS_FETCH) && imem.imem_ack) || (state_r == FS_HOLD);
        if (state_r == FS_HOLD) begin
            word_s = hold_buf_r;
        end else begin
            word_s = imem.imem_rdata;
        end
        fire_s   = word_avail_s && nostall;
        branch_s = (pcsource != PCS_SEQ);
    end

    // Fetch FSM with registered request; parks a word in hold_buf when decode stalls on ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= FS_IDLE;
            req_r      <= 1'b0;
            hold_buf_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                FS_IDLE: begin
                    state_r <= FS_FETCH;
                    req_r   <= 1'b1;
                end
                FS_FETCH: begin
                    if (imem.imem_ack && !nostall) begin
                        hold_buf_r <= imem.imem_rdata;
                        state_r    <= FS_HOLD;
                        req_r      <= 1'b0;
                    end else begin
                        state_r <= FS_FETCH;
                        req_r   <= 1'b1;
                    end
                end
                FS_HOLD: begin
                    if (nostall) begin
                        state_r <= FS_FETCH;
                        req_r   <= 1'b1;
                    end else begin
                        state_r <= FS_HOLD;
                        req_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= FS_IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    // PC and IF/ID register: advance on fire, insert a bubble on a memory wait, hold on stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_r    <= RESET_PC;
            dpc4_r  <= 32'h0000_0000;
            dinst_r <= NOP_INST;
        end else if (fire_s) begin
            pc_r    <= npc_s;
            dpc4_r  <= pc4_s;
            dinst_r <= word_s;
        end else if (nostall) begin
            dinst_r <= NOP_INST;
        end else begin
            pc_r    <= pc_r;
            dpc4_r  <= dpc4_r;
            dinst_r <= dinst_r;
        end
    end

    // Remember a branch that leaves decode while its delay slot is still being fetched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            redirect_pending_r <= 1'b0;
            redirect_pc_r      <= 32'h0000_0000;
        end else if (fire_s) begin
            redirect_pending_r <= 1'b0;
        end else if (nostall && branch_s) begin
            redirect_pending_r <= 1'b1;
            redirect_pc_r      <= target_s;
        end else begin
            redirect_pending_r <= redirect_pending_r;
        end
    end

    assign imem.imem_req  = req_r;
    assign imem.imem_addr = pc_r;
    assign pc             = pc_r;
    assign dpc4           = dpc4_r;
    assign dinst          = dinst_r;

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Self-checking bench for pipe_fetch_unit: directed cycle steps with a
// scoreboard of expected IF/ID contents pushed when a fetch is expected to
// complete and popped after the clock edge that should deliver it.
module tb_pipe_fetch_unit;

    typedef struct packed {
        logic [31:0] dpc4;
        logic [31:0] dinst;
    } ifid_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        nostall = 1'b1;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = 32'h0000_0000;
    logic [31:0] rpc = 32'h0000_0000;
    logic [31:0] jpc = 32'h0000_0000;
    logic [31:0] pc;
    logic [31:0] dpc4;
    logic [31:0] dinst;

    int tests_run = 0;
    int tests_failed = 0;

    ifid_t       sb[$];
    logic [31:0] cur_pc = 32'h0000_0000;
    logic [31:0] exp_dpc4 = 32'h0000_0000;
    logic [31:0] exp_dinst = 32'h0000_0000;

    pipe_fetch_unit_if mem();

    pipe_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .nostall  (nostall),
        .pcsource (pcsource),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .imem     (mem),
        .pc       (pc),
        .dpc4     (dpc4),
        .dinst    (dinst)
    );

    always #5 clock = ~clock;

    // Instruction word the memory model returns for an address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h8C00_0001;
    endfunction

    task automatic check32(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check the bus, then check IF/ID and PC after the edge.
    task automatic step(input logic ns, input logic [1:0] pcs, input logic ack,
                        input logic exp_req, input logic exp_fire, input logic [31:0] exp_pc_next);
        ifid_t e;
        @(negedge clock);
        nostall      = ns;
        pcsource     = pcs;
        mem.imem_ack = ack;
        if (ack) mem.imem_rdata = word_at(cur_pc);
        else     mem.imem_rdata = 32'hDEAD_BEEF;
        #1;
        check32("imem_req", {31'd0, mem.imem_req}, {31'd0, exp_req});
        if (exp_req) check32("imem_addr", mem.imem_addr, cur_pc);
        if (exp_fire) sb.push_back('{dpc4: cur_pc + 32'd4, dinst: word_at(cur_pc)});
        @(posedge clock);
        #1;
        if (exp_fire) begin
            e = sb.pop_front();
            exp_dpc4  = e.dpc4;
            exp_dinst = e.dinst;
        end else if (ns) begin
            exp_dinst = 32'h0000_0000;
        end
        check32("dinst", dinst, exp_dinst);
        check32("dpc4", dpc4, exp_dpc4);
        check32("pc", pc, exp_pc_next);
        cur_pc = exp_pc_next;
    endtask

    initial begin
        mem.imem_ack   = 1'b0;
        mem.imem_rdata = 32'h0000_0000;
        #1 reset = 1'b1;
        #1;
        check32("rst_pc", pc, 32'h0000_0000);
        check32("rst_dpc4", dpc4, 32'h0000_0000);
        check32("rst_dinst", dinst, 32'h0000_0000);
        check32("rst_req", {31'd0, mem.imem_req}, 32'd0);
        @(posedge clock);
        #2 reset = 1'b0;

        // Zero-wait fetch; IDLE cycle ignores ack.
        step(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_0004);
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_0008);
        // Two wait states at 0x8.
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0008);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0008);
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_000C);
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_0010);
        // Decode stall on ack at 0x10: word parked, delivered from hold_buf.
        step(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0000_0010);
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0000_0014);
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_0018);
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_001C);
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_0020);
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_0024);
        // Branch leaves decode while delay slot at 0x24 waits 3 cycles.
        bpc = 32'h0000_0100;
        step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0000_0024);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0024);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0024);
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        // Target select and wrap.
        rpc = 32'h0000_0040;
        step(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
        jpc = 32'h0000_0080;
        step(1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
        jpc = 32'hFFFF_FFFC;
        step(1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_0000);
        // Wait at 0x4 with a captured redirect, then async reset mid-wait.
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_0004);
        step(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0000_0004);
        bpc = 32'h0000_0200;
        step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0000_0004);
        pcsource       = 2'b00;
        mem.imem_ack   = 1'b1;
        mem.imem_rdata = 32'h1234_5678;
        #2 reset = 1'b1;
        #1;
        check32("mid_rst_pc", pc, 32'h0000_0000);
        check32("mid_rst_dpc4", dpc4, 32'h0000_0000);
        check32("mid_rst_dinst", dinst, 32'h0000_0000);
        check32("mid_rst_req", {31'd0, mem.imem_req}, 32'd0);
        cur_pc    = 32'h0000_0000;
        exp_dpc4  = 32'h0000_0000;
        exp_dinst = 32'h0000_0000;
        @(posedge clock);
        #2 reset = 1'b0;
        // Late ack in IDLE ignored; restart at RESET_PC with no surviving redirect.
        step(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_0004);
        step(1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0000_0008);

        check32("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
